switch_arbiter: RTL and testbench
=================================

// Module: switch_arbiter
// PURPOSE
//  Round-robin, packet-locked arbiter that shares one 4:1 `switch` datapath between four
//  valid/ready sources (a,b,c,d) feeding a single NoC output port.
//  Generates the switch select, gates per-source ready and registers the selected beat.
//  Sits in each router output port of the hierarchical mesh, between input buffers and link.
// PARAMETERS
//  DATA_WIDTH  16  width of each data beat (matches `switch`)
//  MAX_BURST   16  max beats per packet before forced release; >=2
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high reset
//  in_valid     in   4           per-source beat valid; bit0=a, bit1=b, bit2=c, bit3=d
//  in_last      in   4           per-source last-beat-of-packet flag
//  in_data_a..d in   DATA_WIDTH  per-source beat data
//  in_ready     out  4           per-source accept; at most one bit high
//  sel          out  4           one-hot switch select (bit0=a..bit3=d); 4'b0000 = none
//  out_valid    out  1           registered output beat valid
//  out_last     out  1           registered last flag
//  out_data     out  DATA_WIDTH  registered output beat
//  out_ready    in   1           downstream accept
//  err_overrun  out  1           1-cycle pulse on forced release
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high. Reset values: state=IDLE, owner=0,
//    rr_ptr=0, beat_cnt=0, out_valid=0, out_last=0, out_data=0, in_ready=0, sel=0, err_overrun=0.
//  - States (arb_state_t): IDLE, BUSY.
//  - IDLE: sel=0, in_ready=0. If any in_valid: owner = first requester at or after rr_ptr
//    (cyclic a->b->c->d->a); -> BUSY, beat_cnt=0. No beat transferred in IDLE.
//  - BUSY: sel=onehot(owner); in_ready[owner] = ~out_valid | out_ready; other bits 0.
//    Beat xfer = in_valid[owner] & in_ready[owner]: load out_data/out_last, out_valid=1,
//    beat_cnt++.
//  - Release on xfer with in_last[owner]=1: -> IDLE, rr_ptr = owner+1 (mod 4).
//  - Forced release: xfer with beat_cnt==MAX_BURST-1 and in_last=0 -> IDLE,
//    rr_ptr = owner+1, err_overrun=1 for one cycle; beat still forwarded with out_last=0.
//  - Output reg: out_valid cleared when out_ready & no new xfer; out_valid & ~out_ready
//    holds out_data/out_last stable (no drop, no overwrite).
//  - Latency: in_valid rising in IDLE -> in_ready next cycle -> out_valid the cycle after
//    (2 cycles min); back-to-back beats sustain 1 beat/cycle while out_ready=1.
//  - Bubble: owner drops in_valid mid-packet -> lock held, no timeout, sel unchanged.
//  - Packet switch costs one IDLE cycle (no beat) between owners.
//  - Single requester only: re-granted each packet; rr_ptr still advances.
//  - in_valid changes on non-owners during BUSY are ignored.
//  - Reset mid-packet: all state to reset values immediately; partial packet discarded.
//  - beat_cnt width $clog2(MAX_BURST); never wraps (release occurs first).
// STRUCTURE
//  - noc_pkg: arb_state_t {IDLE,BUSY}; localparam NUM_SRC=4; typedef logic [1:0] src_idx_t.
//  - Sub-module rr_picker (combinational): req[3:0], ptr -> grant idx + any.
//  - Existing `switch` instance muxes in_data_a..d using sel; in_last muxed by owner;
//    output register in this module.
// TESTING
//  1. Reset, then a sends 3-beat packet 0x0001..0x0003 (last on 3rd), out_ready=1:
//     in_ready[0] at cycle 1, out_data 1,2,3 at cycles 2-4, out_last on 3; sel=4'b0001.
//  2. All four valid with 1-beat packets a=0x10, b=0x20, c=0x30, d=0x40, repeated:
//     out order 10,20,30,40,10..., one IDLE cycle between; sel 0001,0010,0100,1000.
//  3. b mid-packet, out_ready=0 for 3 cycles: out_valid held, out_data frozen,
//     in_ready=0; resume -> no beat lost or duplicated.
//  4. c sends 20 beats without last (MAX_BURST=16): 16 beats forwarded, err_overrun
//     pulses on 16th xfer, grant moves to d if requesting.
//  5. Reset asserted during beat 2 of a 4-beat packet from a: next cycle out_valid=0,
//     sel=0, in_ready=0; after release, b requesting is granted first
//     (rr_ptr=0 but a idle).
//  6. a drops in_valid for 2 cycles mid-packet while b requests: sel stays 0001, b not
//     granted until a's last.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types for the NoC router output-port arbiter.
package noc_pkg;

    localparam int unsigned NUM_SRC = 4;

    typedef logic [1:0] src_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Source index to one-hot switch select
    function automatic logic [NUM_SRC-1:0] onehot(input src_idx_t idx);
        logic [NUM_SRC-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first requester at or after ptr, cyclic a->b->c->d->a.
// Ports: req (per-source request), ptr (search start), grant (picked index), any (some request).
module rr_picker
    import noc_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  src_idx_t           ptr,
    output src_idx_t           grant,
    output logic               any
);

    src_idx_t idx;

    always_comb begin
        grant = ptr;
        any   = 1'b0;
        idx   = ptr;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = ptr + src_idx_t'(i);
            if (!any && req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch.sv
// 4:1 datapath switch driven by a one-hot select; all-zero select yields zero data.
// Ports: sel (one-hot select), in_a..in_d (source beats), out (selected beat).
module switch #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [3:0]            sel,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_c,
    input  logic [DATA_WIDTH-1:0] in_d,
    output logic [DATA_WIDTH-1:0] out
);

    // AND-OR mux: select is one-hot, so at most one term contributes
    always_comb begin
        out = '0;
        if (sel[0]) out = out | in_a;
        if (sel[1]) out = out | in_b;
        if (sel[2]) out = out | in_c;
        if (sel[3]) out = out | in_d;
    end

endmodule

// File: rtl/switch_arbiter.sv
// Packet-locked round-robin arbiter sharing one 4:1 switch between sources a..d
// feeding a single NoC output port, with a registered output beat.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_last[3:0]   per-source beat valid / last flag (bit0=a .. bit3=d)
//   in_data_a..d            per-source beat data
//   in_ready[3:0]           per-source accept (at most one bit high)
//   sel[3:0]                one-hot switch select, 0 = none
//   out_valid/last/data     registered output beat
//   out_ready               downstream accept
//   err_overrun             one-cycle pulse when a packet is force-released
module switch_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    in_valid,
    input  logic [NUM_SRC-1:0]    in_last,
    input  logic [DATA_WIDTH-1:0] in_data_a,
    input  logic [DATA_WIDTH-1:0] in_data_b,
    input  logic [DATA_WIDTH-1:0] in_data_c,
    input  logic [DATA_WIDTH-1:0] in_data_d,
    output logic [NUM_SRC-1:0]    in_ready,
    output logic [NUM_SRC-1:0]    sel,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  err_overrun
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST);

    arb_state_t            state;
    src_idx_t              owner;
    src_idx_t              rr_ptr;
    logic [CNT_W-1:0]      beat_cnt;

    src_idx_t              pick_idx;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] sw_data;
    logic                  owner_ready;
    logic                  xfer;
    logic                  owner_last;
    logic                  burst_end;

    rr_picker u_picker (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (pick_idx),
        .any   (pick_any)
    );

    switch #(.DATA_WIDTH(DATA_WIDTH)) u_switch (
        .sel  (sel),
        .in_a (in_data_a),
        .in_b (in_data_b),
        .in_c (in_data_c),
        .in_d (in_data_d),
        .out  (sw_data)
    );

    // Owner may push a beat whenever the output register is empty or draining
    assign owner_ready = (state == BUSY) && (!out_valid || out_ready);
    assign xfer        = in_valid[owner] && owner_ready;
    assign owner_last  = in_last[owner];
    assign burst_end   = (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_comb begin
        in_ready        = '0;
        in_ready[owner] = owner_ready;
    end

    // Arbitration FSM and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            sel         <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= 1'b0;

            if (xfer) begin
                out_valid <= 1'b1;
                out_last  <= owner_last;
                out_data  <= sw_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner    <= pick_idx;
                        sel      <= onehot(pick_idx);
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        // Release on last beat, or force release at the burst limit
                        if (owner_last || burst_end) begin
                            state       <= IDLE;
                            sel         <= '0;
                            rr_ptr      <= owner + src_idx_t'(1);
                            err_overrun <= !owner_last;
                            beat_cnt    <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter: inputs driven 1ns after the rising edge,
// outputs checked on the falling edge.
module tb_switch_arbiter;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    in_valid;
    logic [3:0]    in_last;
    logic [DW-1:0] in_data_a, in_data_b, in_data_c, in_data_d;
    logic [3:0]    in_ready;
    logic [3:0]    sel;
    logic          out_valid;
    logic          out_last;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          err_overrun;

    int errors = 0;
    int checks = 0;

    switch_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_data_a   (in_data_a),
        .in_data_b   (in_data_b),
        .in_data_c   (in_data_c),
        .in_data_d   (in_data_d),
        .in_ready    (in_ready),
        .sel         (sel),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data_a = '0;
        in_data_b = '0;
        in_data_c = '0;
        in_data_d = '0;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_sel;

        // ---- 1: reset values, then a sends 3-beat packet 1,2,3 ----
        do_reset();
        reset = 1'b0; in_valid = 4'b0001; in_data_a = 16'h0001;
        sample();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_last", 32'(out_last), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_err", 32'(err_overrun), 32'h0);
        tick();
        sample();
        check("t1_c1_sel", 32'(sel), 32'h1);
        check("t1_c1_in_ready", 32'(in_ready), 32'h1);
        check("t1_c1_out_valid", 32'(out_valid), 32'h0);
        tick(); in_data_a = 16'h0002;
        sample();
        check("t1_c2_out_valid", 32'(out_valid), 32'h1);
        check("t1_c2_out_data", 32'(out_data), 32'h1);
        tick(); in_data_a = 16'h0003; in_last = 4'b0001;
        sample();
        check("t1_c3_out_data", 32'(out_data), 32'h2);
        check("t1_c3_out_last", 32'(out_last), 32'h0);
        tick(); in_valid = '0; in_last = '0;
        sample();
        check("t1_c4_out_data", 32'(out_data), 32'h3);
        check("t1_c4_out_last", 32'(out_last), 32'h1);
        check("t1_c4_sel", 32'(sel), 32'h0);
        check("t1_c4_in_ready", 32'(in_ready), 32'h0);
        tick();
        sample();
        check("t1_c5_out_valid", 32'(out_valid), 32'h0);

        // ---- 2: all four requesting 1-beat packets, round robin ----
        do_reset();
        reset = 1'b0; in_valid = 4'b1111; in_last = 4'b1111;
        in_data_a = 16'h10; in_data_b = 16'h20; in_data_c = 16'h30; in_data_d = 16'h40;
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_sel = 4'b0001 << (k % 4);
            sample();
            check("t2_sel", 32'(sel), 32'(exp_sel));
            check("t2_in_ready", 32'(in_ready), 32'(exp_sel));
            tick();
            sample();
            check("t2_out_valid", 32'(out_valid), 32'h1);
            check("t2_out_data", 32'(out_data), 32'((k % 4 + 1) * 16));
            check("t2_out_last", 32'(out_last), 32'h1);
            check("t2_idle_sel", 32'(sel), 32'h0);
            tick();
        end

        // ---- 3: b mid-packet with 3 cycles of downstream backpressure ----
        do_reset();
        reset = 1'b0; in_valid = 4'b0010; in_data_b = 16'h0100;
        tick();
        sample();
        check("t3_sel", 32'(sel), 32'h2);
        check("t3_in_ready", 32'(in_ready), 32'h2);
        tick(); in_data_b = 16'h0101;
        sample();
        check("t3_beat0", 32'(out_data), 32'h100);
        tick(); in_data_b = 16'h0102; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t3_hold_valid", 32'(out_valid), 32'h1);
            check("t3_hold_data", 32'(out_data), 32'h101);
            check("t3_hold_ready", 32'(in_ready), 32'h0);
            tick();
        end
        out_ready = 1'b1; in_last = 4'b0010;
        sample();
        check("t3_resume_ready", 32'(in_ready), 32'h2);
        check("t3_resume_data", 32'(out_data), 32'h101);
        tick(); in_valid = '0; in_last = '0;
        sample();
        check("t3_last_data", 32'(out_data), 32'h102);
        check("t3_last_flag", 32'(out_last), 32'h1);
        check("t3_last_valid", 32'(out_valid), 32'h1);

        // ---- 4: c overruns the burst limit, d waiting ----
        do_reset();
        reset = 1'b0; in_valid = 4'b1100; in_data_c = 16'h0200; in_data_d = 16'h0400;
        tick();
        for (int i = 0; i < 16; i++) begin
            in_data_c = 16'(16'h0200 + i);
            sample();
            check("t4_sel", 32'(sel), 32'h4);
            check("t4_err_low", 32'(err_overrun), 32'h0);
            if (i > 0) check("t4_data", 32'(out_data), 32'(16'h0200 + i - 1));
            tick();
        end
        in_data_c = 16'h0210;
        sample();
        check("t4_err_pulse", 32'(err_overrun), 32'h1);
        check("t4_final_data", 32'(out_data), 32'h20F);
        check("t4_final_last", 32'(out_last), 32'h0);
        check("t4_release_sel", 32'(sel), 32'h0);
        tick(); in_last = 4'b1000;
        sample();
        check("t4_err_cleared", 32'(err_overrun), 32'h0);
        check("t4_d_sel", 32'(sel), 32'h8);
        check("t4_d_in_ready", 32'(in_ready), 32'h8);

        // ---- 5: reset during beat 2 of a's packet ----
        do_reset();
        reset = 1'b0; in_valid = 4'b0001; in_data_a = 16'h0301; in_data_b = 16'h0501;
        tick();
        tick(); in_data_a = 16'h0302; in_valid = 4'b0011; reset = 1'b1;
        sample();
        check("t5_beat1", 32'(out_data), 32'h301);
        tick(); reset = 1'b0; in_valid = 4'b0010;
        sample();
        check("t5_rst_valid", 32'(out_valid), 32'h0);
        check("t5_rst_sel", 32'(sel), 32'h0);
        check("t5_rst_ready", 32'(in_ready), 32'h0);
        check("t5_rst_data", 32'(out_data), 32'h0);
        tick();
        sample();
        check("t5_b_sel", 32'(sel), 32'h2);
        check("t5_b_ready", 32'(in_ready), 32'h2);

        // ---- 6: a bubbles mid-packet, b must wait for a's last ----
        do_reset();
        reset = 1'b0; in_valid = 4'b0001; in_data_a = 16'h0501;
        in_data_b = 16'h0600; in_last = 4'b0010;
        tick();
        in_valid = 4'b0011;
        sample();
        check("t6_c1_sel", 32'(sel), 32'h1);
        tick(); in_valid = 4'b0010;
        sample();
        check("t6_c2_sel", 32'(sel), 32'h1);
        check("t6_c2_data", 32'(out_data), 32'h501);
        check("t6_c2_ready", 32'(in_ready), 32'h1);
        tick();
        sample();
        check("t6_c3_sel", 32'(sel), 32'h1);
        check("t6_c3_ready", 32'(in_ready), 32'h1);
        check("t6_c3_valid", 32'(out_valid), 32'h0);
        tick(); in_valid = 4'b0011; in_data_a = 16'h0502; in_last = 4'b0011;
        sample();
        check("t6_c4_sel", 32'(sel), 32'h1);
        tick(); in_valid = 4'b0010;
        sample();
        check("t6_c5_data", 32'(out_data), 32'h502);
        check("t6_c5_last", 32'(out_last), 32'h1);
        check("t6_c5_sel", 32'(sel), 32'h0);
        tick();
        sample();
        check("t6_c6_b_sel", 32'(sel), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
